// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD MAC accelerator host-bus sequencer.
// Holds the sequencer state encoding, the accelerator register map and
// the default lane count / bus width.
package simd_pkg;

  localparam int unsigned NREG        = 32;
  localparam int unsigned BW          = 8;

  // Accelerator register map: A lanes, then B lanes, then the mode register.
  localparam int unsigned ADDR_A_BASE = 0;
  localparam int unsigned ADDR_B_BASE = 32;
  localparam int unsigned ADDR_MODE   = 64;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    W_SETUP,
    W_STB,
    W_HOLD,
    EXEC_HI,
    EXEC_LO,
    R_STB,
    R_OUT,
    DONE
  } state_t;

endpackage

// File: rtl/bus_strobe_timer.sv
// Strobe-width down-counter shared by the write, execute and read strobes.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : restart the count (asserted on the cycle before a strobe state)
//   expired   : high on the last cycle of a STROBE-long strobe
module bus_strobe_timer
  import simd_pkg::*;
#(
  parameter int unsigned STROBE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int unsigned CW = (STROBE > 1) ? $clog2(STROBE) : 1;

  logic [CW-1:0] r_cnt;

  // Loaded with STROBE-1 so the strobe state lasts exactly STROBE cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= CW'(STROBE - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/simd_bus_sequencer.sv
// Host-bus sequencer for the SIMD MAC accelerator.
// On start: writes NREG A bytes, NREG B bytes and the mode register (each as
// an address write followed by a data write), pulses execute, then reads NREG
// result bytes and presents them on a valid/ready output stream.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   start, mode, keep_b          : job command (sampled in IDLE)
//   busy, done                   : job status
//   in_data/in_valid/in_ready    : operand byte stream (A then B)
//   out_data/out_valid/out_ready : result byte stream
//   bus_cs/wr/rd/ad/exec, bus_dout, bus_din : accelerator byte bus
// Configuration macro: SEQ_KEEP_B_EN -- when defined, keep_b skips the B writes.
module simd_bus_sequencer
  import simd_pkg::*;
#(
  parameter int unsigned STROBE = 2,
  parameter int unsigned NREG   = simd_pkg::NREG,
  parameter int unsigned BW     = simd_pkg::BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          keep_b,
  output logic          busy,
  output logic          done,
  input  logic [BW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [BW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          bus_cs,
  output logic          bus_wr,
  output logic          bus_rd,
  output logic          bus_ad,
  output logic          bus_exec,
  output logic [BW-1:0] bus_dout,
  input  logic [BW-1:0] bus_din
);

  localparam int unsigned IDXW       = $clog2(2 * NREG + 1);
  localparam int unsigned RCW        = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned L_MODE_IDX = 2 * NREG;
  localparam int unsigned L_LAST_A   = NREG - 1;

  state_t          r_state, w_state_nxt;
  logic [IDXW-1:0] r_idx, w_idx_nxt;
  logic            r_phase_addr, w_phase_addr_nxt;
  logic [BW-1:0]   r_data, w_data_nxt;
  logic [1:0]      r_mode, w_mode_nxt;
  logic [RCW-1:0]  r_rcnt, w_rcnt_nxt;

  logic            r_busy, r_done, r_in_ready, r_out_valid;
  logic [BW-1:0]   r_out_data, w_out_data_nxt;
  logic            r_cs, r_wr, r_rd, r_ad, r_exec;
  logic [BW-1:0]   r_dout, w_dout_nxt;
  logic            w_in_write;

  logic            w_keep_b;
  logic            w_skip_b;
  logic            w_load;
  logic            w_expired;

`ifdef SEQ_KEEP_B_EN
  logic r_keep_b;

  // keep_b is a per-job option, captured alongside mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_keep_b <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_keep_b <= keep_b;
    end
  end

  assign w_keep_b = r_keep_b;
`else
  logic w_unused_keep_b;

  assign w_unused_keep_b = keep_b;
  assign w_keep_b        = 1'b0;
`endif

  // Jump straight from the last A lane to the mode register when B is kept.
  assign w_skip_b = w_keep_b && (r_idx == IDXW'(L_LAST_A));

  // Restart the strobe timer on entry to any strobe state.
  assign w_load = (w_state_nxt != r_state) &&
                  (w_state_nxt inside {W_STB, EXEC_HI, R_STB});

  bus_strobe_timer #(
    .STROBE (STROBE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .expired (w_expired)
  );

  // Next-state and datapath
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_phase_addr_nxt = r_phase_addr;
    w_data_nxt       = r_data;
    w_mode_nxt       = r_mode;
    w_rcnt_nxt       = r_rcnt;
    w_out_data_nxt   = r_out_data;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_mode_nxt       = mode;
          w_idx_nxt        = '0;
          w_phase_addr_nxt = 1'b1;
          w_state_nxt      = FETCH;
        end
      end
      FETCH: begin
        if (in_valid) begin
          w_data_nxt       = in_data;
          w_phase_addr_nxt = 1'b1;
          w_state_nxt      = W_SETUP;
        end
      end
      W_SETUP: w_state_nxt = W_STB;
      W_STB: begin
        if (w_expired) begin
          w_state_nxt = W_HOLD;
        end
      end
      W_HOLD: begin
        if (r_phase_addr) begin
          w_phase_addr_nxt = 1'b0;
          w_state_nxt      = W_SETUP;
        end else if (r_idx == IDXW'(L_MODE_IDX)) begin
          w_state_nxt = EXEC_HI;
        end else begin
          w_phase_addr_nxt = 1'b1;
          w_idx_nxt        = w_skip_b ? IDXW'(L_MODE_IDX) : r_idx + IDXW'(1);
          // The mode register needs no stream byte; its data is the latched mode.
          if (w_idx_nxt == IDXW'(L_MODE_IDX)) begin
            w_data_nxt  = BW'(r_mode);
            w_state_nxt = W_SETUP;
          end else begin
            w_state_nxt = FETCH;
          end
        end
      end
      EXEC_HI: begin
        if (w_expired) begin
          w_state_nxt = EXEC_LO;
        end
      end
      EXEC_LO: begin
        w_rcnt_nxt  = '0;
        w_state_nxt = R_STB;
      end
      R_STB: begin
        if (w_expired) begin
          w_out_data_nxt = bus_din;
          w_state_nxt    = R_OUT;
        end
      end
      R_OUT: begin
        if (out_ready) begin
          if (r_rcnt == RCW'(NREG - 1)) begin
            w_state_nxt = DONE;
          end else begin
            w_rcnt_nxt  = r_rcnt + RCW'(1);
            w_state_nxt = R_STB;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe.
  assign w_in_write = w_state_nxt inside {W_SETUP, W_STB, W_HOLD};
  assign w_dout_nxt = !w_in_write      ? '0 :
                      w_phase_addr_nxt ? BW'(w_idx_nxt) : w_data_nxt;

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_phase_addr <= 1'b1;
      r_data       <= '0;
      r_mode       <= '0;
      r_rcnt       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_cs         <= 1'b0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_ad         <= 1'b0;
      r_exec       <= 1'b0;
      r_dout       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_phase_addr <= w_phase_addr_nxt;
      r_data       <= w_data_nxt;
      r_mode       <= w_mode_nxt;
      r_rcnt       <= w_rcnt_nxt;
      r_busy       <= !(w_state_nxt inside {IDLE, DONE});
      r_done       <= (w_state_nxt == DONE);
      r_in_ready   <= (w_state_nxt == FETCH);
      r_out_valid  <= (w_state_nxt == R_OUT);
      r_out_data   <= w_out_data_nxt;
      r_cs         <= !(w_state_nxt inside {IDLE, DONE});
      r_wr         <= (w_state_nxt == W_STB);
      r_rd         <= (w_state_nxt == R_STB);
      r_ad         <= w_in_write && w_phase_addr_nxt;
      r_exec       <= (w_state_nxt == EXEC_HI);
      r_dout       <= w_dout_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign bus_cs    = r_cs;
  assign bus_wr    = r_wr;
  assign bus_rd    = r_rd;
  assign bus_ad    = r_ad;
  assign bus_exec  = r_exec;
  assign bus_dout  = r_dout;

endmodule

// File: tb/tb_simd_bus_sequencer.sv
// Directed testbench for simd_bus_sequencer (STROBE=2, NREG=32, BW=8).
// A bus monitor logs accelerator writes/strobes and the output stream; a tiny
// accelerator model returns 0xA0+k on read k. Honours SEQ_KEEP_B_EN.
module tb_simd_bus_sequencer;

`ifdef SEQ_KEEP_B_EN
  localparam bit KEEP_EN = 1'b1;
`else
  localparam bit KEEP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, keep_b, in_valid, out_ready;
  logic [1:0] mode;
  logic [7:0] in_data, out_data, bus_dout, bus_din;
  logic       busy, done, in_ready, out_valid;
  logic       bus_cs, bus_wr, bus_rd, bus_ad, bus_exec;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simd_bus_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .keep_b    (keep_b),
    .busy      (busy),
    .done      (done),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bus_cs    (bus_cs),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_ad    (bus_ad),
    .bus_exec  (bus_exec),
    .bus_dout  (bus_dout),
    .bus_din   (bus_din)
  );

  // Bus monitor and accelerator read model
  logic [8:0] wlog[$];
  logic [7:0] oq[$];
  logic [8:0] exp_w[$];
  logic [7:0] stim [64];
  logic       mon_clr = 1'b0;
  int n_exec = 0, n_rd = 0, rd_k = 0, n_cons = 0, n_done = 0;
  int n_stall_bad = 0, n_hold_bad = 0;
  logic p_wr = 1'b0, p_rd = 1'b0, p_ov = 1'b0, p_or = 1'b0;
  logic [7:0] p_od = 8'h00;

  assign bus_din = 8'(8'hA0 + 8'(rd_k));

  always @(negedge clk) begin
    if (mon_clr) begin
      wlog.delete(); oq.delete();
      n_exec = 0; n_rd = 0; rd_k = 0; n_cons = 0; n_done = 0;
      n_stall_bad = 0; n_hold_bad = 0;
      p_wr = 1'b0; p_rd = 1'b0; p_ov = 1'b0; p_or = 1'b0; p_od = 8'h00;
    end else begin
      if (bus_wr && !p_wr) wlog.push_back({bus_ad, bus_dout});
      if (bus_exec) n_exec++;
      if (bus_rd && !p_rd) n_rd++;
      if (!bus_rd && p_rd) rd_k++;
      if (in_valid && in_ready) n_cons++;
      if (out_valid && out_ready) oq.push_back(out_data);
      if (done) n_done++;
      if ((in_ready || out_valid) && (bus_wr || bus_rd || bus_exec)) n_stall_bad++;
      if (in_ready && !bus_cs) n_stall_bad++;
      if (p_ov && !p_or && (!out_valid || out_data !== p_od)) n_hold_bad++;
      p_wr = bus_wr; p_rd = bus_rd; p_ov = out_valid; p_or = out_ready; p_od = out_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected accelerator write log: (ad, byte) pairs for each register.
  task automatic build_exp(input bit kb, input logic [1:0] md);
    exp_w.delete();
    for (int i = 0; i <= 64; i++) begin
      if (kb && i >= 32 && i < 64) continue;
      exp_w.push_back({1'b1, 8'(i)});
      exp_w.push_back({1'b0, (i == 64) ? {6'b0, md} : stim[i]});
    end
  endtask

  // Drives one job; stops at done, at the cycle budget, or when the address
  // write of register abort_idx is strobing.
  task automatic run_job(input bit stall, input bit hold_start, input bit kb,
                         input logic [1:0] md, input int abort_idx,
                         output int cycles, output bit finished);
    int ptr;
    bit rdy_q;
    ptr = 0; rdy_q = 1'b0; cycles = 0; finished = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = stim[0];
    start = 1'b1; mode = md; keep_b = kb;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      cycles++;
      if (!hold_start) start = 1'b0;
      if (in_valid && rdy_q) ptr++;
      rdy_q = in_ready;
      if (done) begin
        start = 1'b0; finished = 1'b1;
        break;
      end
      if (abort_idx >= 0 && bus_wr && bus_ad && bus_dout == 8'(abort_idx)) begin
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        break;
      end
      in_valid  = (ptr < 64) && (!stall || $urandom_range(0, 3) != 0);
      in_data   = stim[(ptr < 64) ? ptr : 63];
      out_ready = !stall || ($urandom_range(0, 2) != 0);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (finished) repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, in_ready, out_valid, bus_cs, bus_wr, bus_rd, bus_ad, bus_exec} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {busy, done, in_ready, out_valid, bus_cs, bus_wr, bus_rd, bus_ad, bus_exec});
    end
    n_cmp++;
    if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++;
    if (bus_dout !== 8'h00) begin n_err++; $display("FAIL reset_bus_dout: got %h want 00", bus_dout); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_full_job();
    int cyc, bad;
    bit fin;
    for (int i = 0; i < 64; i++) stim[i] = (i < 32) ? 8'(i) : 8'h01;
    build_exp(1'b0, 2'd0);
    run_job(1'b0, 1'b0, 1'b0, 2'd0, -1, cyc, fin);
    n_cmp++;
    if (fin !== 1'b1) begin n_err++; $display("FAIL full_finished: got %b want 1", fin); end
    n_cmp++;
    if (cyc != 684) begin n_err++; $display("FAIL full_cycles: got %0d want 684", cyc); end
    n_cmp++;
    if (wlog.size() != 130) begin n_err++; $display("FAIL full_nwrites: got %0d want 130", wlog.size()); end
    bad = (wlog.size() != exp_w.size()) ? 1 : 0;
    for (int k = 0; k < wlog.size() && k < exp_w.size(); k++) if (wlog[k] !== exp_w[k]) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL full_wlog: bad entries got %0d want 0", bad); end
    n_cmp++;
    if (n_exec != 2) begin n_err++; $display("FAIL full_exec_cycles: got %0d want 2", n_exec); end
    n_cmp++;
    if (n_rd != 32) begin n_err++; $display("FAIL full_reads: got %0d want 32", n_rd); end
    n_cmp++;
    if (n_cons != 64) begin n_err++; $display("FAIL full_consumed: got %0d want 64", n_cons); end
    n_cmp++;
    if (n_done != 1) begin n_err++; $display("FAIL full_done_pulses: got %0d want 1", n_done); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_read_stream();
    int cyc, bad;
    bit fin;
    for (int i = 0; i < 64; i++) stim[i] = 8'(8'hF0 - 8'(i));
    run_job(1'b0, 1'b0, 1'b0, 2'd1, -1, cyc, fin);
    bad = 0;
    for (int k = 0; k < oq.size(); k++) if (oq[k] !== 8'(8'hA0 + 8'(k))) bad++;
    n_cmp++;
    if (oq.size() != 32) begin n_err++; $display("FAIL rd_count: got %0d want 32", oq.size()); end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL rd_order: bad bytes got %0d want 0", bad); end
    n_cmp++;
    if (fin !== 1'b1 || n_done != 1) begin
      n_err++; $display("FAIL rd_done: got fin=%b pulses=%0d want fin=1 pulses=1", fin, n_done);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_after: got %b want 0", out_valid); end
  endtask

  task automatic test_stalls();
    int cyc, bad;
    bit fin;
    for (int i = 0; i < 64; i++) stim[i] = 8'(i * 7 + 3);
    build_exp(1'b0, 2'd2);
    run_job(1'b1, 1'b0, 1'b0, 2'd2, -1, cyc, fin);
    n_cmp++;
    if (fin !== 1'b1 || cyc < 684) begin
      n_err++; $display("FAIL stall_finish: got fin=%b cycles=%0d want fin=1 cycles>=684", fin, cyc);
    end
    bad = (wlog.size() != exp_w.size()) ? 1 : 0;
    for (int k = 0; k < wlog.size() && k < exp_w.size(); k++) if (wlog[k] !== exp_w[k]) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL stall_wlog: bad entries got %0d want 0", bad); end
    bad = (oq.size() != 32) ? 1 : 0;
    for (int k = 0; k < oq.size(); k++) if (oq[k] !== 8'(8'hA0 + 8'(k))) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL stall_order: bad bytes got %0d want 0", bad); end
    n_cmp++;
    if (n_stall_bad != 0) begin n_err++; $display("FAIL stall_strobes: got %0d want 0", n_stall_bad); end
    n_cmp++;
    if (n_hold_bad != 0) begin n_err++; $display("FAIL stall_out_hold: got %0d want 0", n_hold_bad); end
  endtask

  task automatic test_reset_mid();
    int cyc, bad;
    bit fin;
    for (int i = 0; i < 64; i++) stim[i] = 8'(8'h55 ^ 8'(i));
    run_job(1'b0, 1'b0, 1'b0, 2'd3, 40, cyc, fin);
    n_cmp++;
    if (!(bus_wr === 1'b1 && bus_ad === 1'b1 && bus_dout === 8'd40)) begin
      n_err++; $display("FAIL abort_point: got wr=%b ad=%b dout=%0d want 1 1 40", bus_wr, bus_ad, bus_dout);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, in_ready, out_valid, bus_cs, bus_wr, bus_rd, bus_ad, bus_exec} !== 9'b0 ||
        out_data !== 8'h00 || bus_dout !== 8'h00) begin
      n_err++;
      $display("FAIL abort_outputs: got ctrl=%b out=%h dout=%h want 0",
               {busy, done, in_ready, out_valid, bus_cs, bus_wr, bus_rd, bus_ad, bus_exec}, out_data, bus_dout);
    end
    rst = 1'b0;
    build_exp(1'b0, 2'd3);
    run_job(1'b0, 1'b0, 1'b0, 2'd3, -1, cyc, fin);
    n_cmp++;
    if (fin !== 1'b1 || cyc != 684) begin
      n_err++; $display("FAIL rerun_cycles: got fin=%b cycles=%0d want 1 684", fin, cyc);
    end
    bad = (wlog.size() != exp_w.size()) ? 1 : 0;
    for (int k = 0; k < wlog.size() && k < exp_w.size(); k++) if (wlog[k] !== exp_w[k]) bad++;
    bad += (oq.size() != 32) ? 1 : 0;
    for (int k = 0; k < oq.size(); k++) if (oq[k] !== 8'(8'hA0 + 8'(k))) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL rerun_data: bad entries got %0d want 0", bad); end
  endtask

  task automatic test_keep_b();
    int cyc, bad, nb;
    bit fin;
    for (int i = 0; i < 64; i++) stim[i] = 8'(8'h10 + 8'(i));
    build_exp(KEEP_EN, 2'd1);
    run_job(1'b0, 1'b0, 1'b1, 2'd1, -1, cyc, fin);
    n_cmp++;
    if (n_cons != (KEEP_EN ? 32 : 64)) begin
      n_err++; $display("FAIL keep_consumed: got %0d want %0d", n_cons, KEEP_EN ? 32 : 64);
    end
    n_cmp++;
    if (fin !== 1'b1 || cyc != (KEEP_EN ? 396 : 684)) begin
      n_err++; $display("FAIL keep_cycles: got fin=%b cycles=%0d want 1 %0d", fin, cyc, KEEP_EN ? 396 : 684);
    end
    nb = 0;
    for (int k = 0; k < wlog.size(); k++) if (wlog[k][8] && wlog[k][7:0] >= 8'd32 && wlog[k][7:0] < 8'd64) nb++;
    n_cmp++;
    if (nb != (KEEP_EN ? 0 : 32)) begin
      n_err++; $display("FAIL keep_b_addrs: got %0d want %0d", nb, KEEP_EN ? 0 : 32);
    end
    bad = (wlog.size() != exp_w.size()) ? 1 : 0;
    for (int k = 0; k < wlog.size() && k < exp_w.size(); k++) if (wlog[k] !== exp_w[k]) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL keep_wlog: bad entries got %0d want 0", bad); end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    bit fin;
    for (int i = 0; i < 64; i++) stim[i] = 8'(i);
    run_job(1'b0, 1'b1, 1'b0, 2'd0, -1, cyc, fin);
    n_cmp++;
    if (fin !== 1'b1 || cyc != 684) begin
      n_err++; $display("FAIL busy_start_cycles: got fin=%b cycles=%0d want 1 684", fin, cyc);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (n_done != 1) begin n_err++; $display("FAIL busy_start_done: got %0d want 1", n_done); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start_idle: got %b want 0", busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; keep_b = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_full_job();
    test_read_stream();
    test_stalls();
    test_reset_mid();
    test_keep_b();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/simd_bus_sequencer.md
# simd_bus_sequencer

Single-clock controller that drives the SIMD MAC accelerator's byte-wide host bus (CS/WR/RD/AD/excute) so a caller sees a simple command plus streaming interface. On `start` it writes 32 operand-A bytes, 32 operand-B bytes and the mode register, pulses execute, reads back all 32 result bytes, and presents them on an output stream. It sits between the on-chip host logic (the Pico bridge) and the accelerator, replacing bit-banged bus sequencing.

## Interface
- `STROBE`, default 2: cycles WR/RD/excute are held high per strobe (≥1).
- `NREG`, default 32: lanes per operand array.
- `BW`, default 8: bus/data width.
- `clk  in  1  sole clock`
- `rst  in  1  synchronous, active-high reset`
- `start  in  1  begin one job; sampled only in IDLE`
- `mode  in  2  MAC mode; latched on accepted start`
- `keep_b  in  1  skip B reload (only with SEQ_KEEP_B_EN); latched on start`
- `busy  out  1  high from the cycle after an accepted start until `done``
- `done  out  1  one-cycle pulse after the last result byte is accepted`
- `in_data  in  BW  operand byte stream, A[0..31] then B[0..31]`
- `in_valid  in  1` / `in_ready  out  1`: transfer on `in_valid & in_ready`.
- `out_data  out  BW  result byte stream`
- `out_valid  out  1` / `out_ready  in  1`: transfer on `out_valid & out_ready`.
- `bus_cs, bus_wr, bus_rd, bus_ad, bus_exec  out  1  accelerator strobes` (registered).
- `bus_dout  out  BW  byte driven to the accelerator`
- `bus_din  in  BW  byte read from the accelerator`

## Operation
- States: IDLE, FETCH, W_SETUP, W_STB, W_HOLD, EXEC_HI, EXEC_LO, R_STB, R_OUT, DONE.
- IDLE: `start` latches mode/keep_b, clears reg index `idx=0`, phase=ADDR, goes to FETCH.
- Write sequence per register `idx` (0..64): an address write (`bus_ad=1`, `bus_dout=idx`), then a data write (`bus_ad=0`). Data is the operand byte for idx<64; `{6'b0,mode}` for idx=64.
- FETCH (idx<64 only): `in_ready=1`; on transfer capture the byte into the data holding register, then go to W_SETUP (address phase). idx=64 bypasses FETCH.
- Each write: W_SETUP (1 cycle, cs=1, wr=0, ad/dout valid) → W_STB (STROBE cycles, wr=1) → W_HOLD (1 cycle, wr=0, ad/dout held). After the address write, go to W_SETUP for the data write. After the data write, increment idx; next is FETCH, or W_SETUP for idx=64, or EXEC_HI after idx=64.
- With keep_b active, idx jumps from 31 to 64.
- EXEC_HI: STROBE cycles with `bus_exec=1`. EXEC_LO: 1 cycle with exec=0; the falling edge captures the results.
- Read loop, 32 iterations: R_STB holds rd=1 for STROBE cycles and captures `bus_din` into `out_data` on the last R_STB cycle. R_OUT has rd=0 and `out_valid=1` until `out_ready`. Result bytes emerge lane 31 first (MSB lane) down to lane 0.
- DONE: `done=1` for one cycle, then IDLE.
- `bus_cs=1` in every non-IDLE/FETCH/DONE state. It is also held high through FETCH stalls between phases; it is only low in IDLE and DONE.
- `start` while busy is ignored.

## Timing
- Reset (synchronous, takes effect at the next clk edge, from any state): state=IDLE and all outputs 0. This covers busy, done, in_ready, out_valid, out_data, bus_*, and bus_dout. An aborted job leaves accelerator contents undefined; the caller re-runs.
- Minimum write cost: STROBE+2 cycles. Each operand register costs 2 writes + 1 FETCH cycle.
- Full job with STROBE=2, no stalls:
  - 64×(1+8) + 8 (mode) + 3 (exec) + 32×(2+1) + 1 = 684 cycles from start to done.
- `in_valid` or `out_ready` stalls extend FETCH or R_OUT indefinitely; bus strobes stay low during stalls.
- `out_data` is stable while `out_valid` is high.

## Configuration
- `SEQ_KEEP_B_EN` defined: `keep_b` is honoured. B writes are skipped and the input stream supplies only 32 bytes (A).
- Undefined: `keep_b` is ignored and the logic is not generated; the stream always carries 64 bytes.

## Structure
- Shared package `simd_pkg` holds:
  - state enum;
  - address constants `ADDR_A_BASE=0`, `ADDR_B_BASE=32`, `ADDR_MODE=64`;
  - `NREG`, `BW`.
- One sub-module, `bus_strobe_timer`: a STROBE-length down-counter with `load`/`expired`, shared by W_STB, EXEC_HI and R_STB.

## Test plan
- Reset, then job with A[i]=i, B[i]=1, mode=0, STROBE=2 → bus log shows 130 writes with addresses 0..64 in order and mode data 0x00; exec high 2 cycles; 32 reads; done at cycle 684.
- Accelerator model returning 0xA0+k on read k → out_data sequence 0xA0..0xBF, 32 transfers, then done.
- Random `in_valid`/`out_ready` deassertion → strobes never high during FETCH/R_OUT stalls; byte order unchanged.
- `rst` asserted in W_STB of idx=40 → next cycle all outputs 0, IDLE; a new start completes a correct job.
- With `SEQ_KEEP_B_EN` and keep_b=1 → only 32 in_data bytes consumed; no addresses 32..63 on the bus; mode written at 64.
- `start` pulsed while busy → ignored; exactly one done pulse.
